// File: rtl/spatz_vfu_sequencer_pkg.sv
// Shared types for the Spatz VFU sequencer.
//
// Provides:
//   - vector-length constants and the byte-arithmetic width (ByteW)
//   - vlen_t, vew_e, vtype_t, op_e and the request struct spatz_req_t
//   - seq_state_e, the two-state sequencer FSM encoding
//   - beat_bytes() / vreg_off_w(): derive beat size in bytes and the width
//     of the beat index inside a register group from the lane count
package spatz_pkg;

    localparam int unsigned VLEN  = 512;
    localparam int unsigned VLENB = VLEN / 8;

    // A full LMUL=8 register group spans 8*VLENB bytes. The extra bit keeps
    // an end pointer equal to that span representable.
    localparam int unsigned ByteW = $clog2(8 * VLENB) + 1;

    typedef logic [ByteW-1:0] vlen_t;

    typedef enum logic [1:0] {
        EW_8  = 2'd0,
        EW_16 = 2'd1,
        EW_32 = 2'd2,
        EW_64 = 2'd3
    } vew_e;

    typedef struct packed {
        logic       vill;
        logic       vma;
        logic       vta;
        vew_e       vsew;
        logic [2:0] vlmul;
    } vtype_t;

    typedef enum logic [3:0] {
        OP_VADD  = 4'd0,
        OP_VSUB  = 4'd1,
        OP_VMUL  = 4'd2,
        OP_VMACC = 4'd3,
        OP_VAND  = 4'd4,
        OP_VOR   = 4'd5,
        OP_VXOR  = 4'd6,
        OP_VSLL  = 4'd7
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        vtype_t     vtype;
        vlen_t      vl;
        vlen_t      vstart;
    } spatz_req_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    // Each lane is 32 bit wide, so a beat carries four bytes per lane.
    function automatic int unsigned beat_bytes(input int unsigned nr_lanes);
        return nr_lanes * 4;
    endfunction

    // Number of beats in a full register group, as an index width (min 1).
    function automatic int unsigned vreg_off_w(input int unsigned nr_lanes);
        int unsigned beats;
        beats = (8 * VLENB) / beat_bytes(nr_lanes);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/spatz_vfu_sequencer.sv
// Spatz VFU sequencer: accepts one decoded vector request at a time and
// splits its active byte range [vstart<<vsew, vl<<vsew) into lane beats of
// BeatB bytes, each with a beat index and byte enables.
//
// Optional feature macro: SPATZ_VFU_SEQ_STALL_CNT_EN
//   defined   -> stall_cnt_o counts cycles with beat_valid_o && !beat_ready_i
//                (saturating at 2^32-1)
//   undefined -> stall_cnt_o is constant zero, no counter flops
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   spatz_req_valid_i/_ready_o/_i      request handshake and payload
//   beat_valid_o / beat_ready_i        beat handshake
//   beat_op_o, beat_vd_o/vs1_o/vs2_o   latched operation and registers
//   beat_off_o                         beat index within the register group
//   beat_be_o                          per-byte enables of the current beat
//   beat_last_o                        final beat of the instruction
//   busy_o                             high while in RUN
//   done_o                             one-cycle completion pulse
//   stall_cnt_o                        beat back-pressure counter
//
// FSM:
//   state    | meaning
//   SEQ_IDLE | ready for a request; empty requests complete from here
//   SEQ_RUN  | emitting beats until the last one is accepted
module spatz_vfu_sequencer
    import spatz_pkg::*;
#(
    parameter int unsigned NrLanes     = 4,
    parameter type         spatz_req_t = spatz_pkg::spatz_req_t,
    localparam int unsigned BeatB      = beat_bytes(NrLanes),
    localparam int unsigned VregOffW   = vreg_off_w(NrLanes)
) (
    input  logic                clk_i,
    input  logic                rst_ni,

    input  logic                spatz_req_valid_i,
    output logic                spatz_req_ready_o,
    input  spatz_req_t          spatz_req_i,

    output logic                beat_valid_o,
    input  logic                beat_ready_i,
    output op_e                 beat_op_o,
    output logic [4:0]          beat_vd_o,
    output logic [4:0]          beat_vs1_o,
    output logic [4:0]          beat_vs2_o,
    output logic [VregOffW-1:0] beat_off_o,
    output logic [BeatB-1:0]    beat_be_o,
    output logic                beat_last_o,

    output logic                busy_o,
    output logic                done_o,
    output logic [31:0]         stall_cnt_o
);

    localparam int unsigned BeatShift = $clog2(BeatB);

    seq_state_e state_q;
    vlen_t      ptr_q;
    vlen_t      end_q;
    op_e        op_q;
    logic [4:0] vd_q;
    logic [4:0] vs1_q;
    logic [4:0] vs2_q;
    logic       done_q;

    vlen_t      start_b;
    vlen_t      end_b;
    vlen_t      beat_base;
    vlen_t      ptr_d;
    logic       last_beat;
    logic       beat_hs;

    // Only vl, vstart, vsew and the register/op fields steer the sequencer.
    logic       unused_req;
    assign unused_req = ^spatz_req_i;

    // Byte enable for every byte of the beat whose address lies in [lo, hi).
    function automatic logic [BeatB-1:0] calc_be(input vlen_t base,
                                                 input vlen_t lo,
                                                 input vlen_t hi);
        logic [BeatB-1:0] be;
        vlen_t            addr;
        be = '0;
        for (int unsigned i = 0; i < BeatB; i++) begin
            addr  = base + vlen_t'(i);
            be[i] = (addr >= lo) && (addr < hi);
        end
        return be;
    endfunction

    assign start_b   = spatz_req_i.vstart << spatz_req_i.vtype.vsew;
    assign end_b     = spatz_req_i.vl << spatz_req_i.vtype.vsew;

    // Round the pointer down to its beat, then step to the next boundary.
    assign beat_base = (ptr_q >> BeatShift) << BeatShift;
    assign ptr_d     = beat_base + vlen_t'(BeatB);
    assign last_beat = (ptr_d >= end_q);
    assign beat_hs   = (state_q == SEQ_RUN) && beat_ready_i;

    assign spatz_req_ready_o = (state_q == SEQ_IDLE);
    assign busy_o            = (state_q == SEQ_RUN);
    assign beat_valid_o      = (state_q == SEQ_RUN);
    assign done_o            = done_q;

    assign beat_op_o   = op_q;
    assign beat_vd_o   = vd_q;
    assign beat_vs1_o  = vs1_q;
    assign beat_vs2_o  = vs2_q;
    assign beat_off_o  = VregOffW'(ptr_q >> BeatShift);
    assign beat_be_o   = calc_be(beat_base, ptr_q, end_q);
    assign beat_last_o = last_beat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEQ_IDLE;
            ptr_q   <= '0;
            end_q   <= '0;
            op_q    <= OP_VADD;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (spatz_req_valid_i) begin
                        op_q  <= spatz_req_i.op;
                        vd_q  <= spatz_req_i.vd;
                        vs1_q <= spatz_req_i.vs1;
                        vs2_q <= spatz_req_i.vs2;
                        ptr_q <= start_b;
                        end_q <= end_b;
                        // Empty body: complete without ever leaving IDLE.
                        if (start_b >= end_b) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= SEQ_RUN;
                        end
                    end
                end
                SEQ_RUN: begin
                    if (beat_hs) begin
                        ptr_q <= ptr_d;
                        if (last_beat) begin
                            state_q <= SEQ_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

`ifdef SPATZ_VFU_SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (beat_valid_o && !beat_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/spatz_vfu_sequencer.md
SPATZ_VFU_SEQUENCER -- requirements
Module: spatz_vfu_sequencer

Interface
REQ-001 SHALL have parameter NrLanes, default 4: lanes per beat; each lane is 32 bit, so one beat is NrLanes*4 bytes (BeatB).
REQ-002 SHALL have parameter spatz_req_t, default spatz_pkg::spatz_req_t: request type accepted from the controller.
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port spatz_req_valid_i  input  1  decoded VFU request valid.
REQ-006 SHALL have port spatz_req_ready_o  output  1  request accepted when high together with valid.
REQ-007 SHALL have port spatz_req_i  input  spatz_req_t  op, vd, vs1, vs2, vtype, vl, vstart.
REQ-008 SHALL have port beat_valid_o  input/output pair beat_ready_i  1 each  lane-beat handshake.
REQ-009 SHALL have port beat_op_o  output  op_e  latched operation.
REQ-010 SHALL have ports beat_vd_o, beat_vs1_o, beat_vs2_o  output  5 each  latched register indices.
REQ-011 SHALL have port beat_off_o  output  VregOffW  beat index within the register group.
REQ-012 SHALL have port beat_be_o  output  BeatB  byte enables for the beat.
REQ-013 SHALL have port beat_last_o  output  1  final beat of the instruction.
REQ-014 SHALL have ports busy_o and done_o  output  1 each: busy is high in RUN; done is a one-cycle pulse on completion.
REQ-015 SHALL have port stall_cnt_o  output  32  beat back-pressure counter (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE and RUN.
REQ-017 spatz_req_ready_o SHALL be high only in IDLE; an accepting handshake SHALL latch all request fields.
REQ-018 On accept, byte pointer SHALL be set to vstart<<vsew and end byte to vl<<vsew. vsew SHALL use EW_8=0, EW_16=1, EW_32=2.
REQ-019 If vstart>=vl, the block SHALL stay in IDLE, emit no beats, and pulse done_o in the next cycle.
REQ-020 Otherwise the FSM SHALL go to RUN in the next cycle; the first beat_valid_o SHALL be one cycle after accept.
REQ-021 beat_off_o SHALL equal ptr/BeatB.
REQ-022 beat_be_o bit i SHALL be set iff the beat byte address (beat_off_o*BeatB + i) lies in [ptr, end).
REQ-023 beat_valid_o SHALL stay high with stable outputs until beat_ready_i; on each handshake ptr SHALL advance to the next BeatB boundary.
REQ-024 beat_last_o SHALL be high iff the next boundary is >= end; its handshake SHALL return the FSM to IDLE and pulse done_o in the same edge.
REQ-025 A new request SHALL NOT be accepted in the cycle the last beat completes; it SHALL be accepted from the following cycle.
REQ-026 All byte arithmetic SHALL be unsigned and $clog2(8*VLENB)+1 bits wide so that vl=MAXVL at EW_32 does not wrap.

Reset
REQ-027 Asserting rst_ni SHALL force IDLE; busy_o, done_o, beat_valid_o and stall_cnt_o SHALL reset to 0, and spatz_req_ready_o SHALL reset to 1.
REQ-028 Reset in RUN SHALL drop the in-flight instruction with no done_o pulse.

Configuration
REQ-029 With SPATZ_VFU_SEQ_STALL_CNT_EN defined, stall_cnt_o SHALL count cycles with beat_valid_o&&!beat_ready_i, saturating at 2^32-1.
REQ-030 Without SPATZ_VFU_SEQ_STALL_CNT_EN, stall_cnt_o SHALL be tied to '0 and no counter flops SHALL exist.

Structure
REQ-031 BeatB/VregOffW derivation helpers and the FSM state enum SHALL live in spatz_pkg; vlen_t, vtype_t and op_e SHALL be reused from there.
REQ-032 No sub-module; a single sequential block plus one combinational byte-enable function.

Verification
REQ-033 NrLanes=4, EW_32, vstart=0, vl=16, ready always high -> 4 beats, off 0..3, be=16'hFFFF, last on beat 3, done on beat-3 edge.
REQ-034 EW_32, vl=5 -> 2 beats; beat 1 be=16'h000F with last=1.
REQ-035 EW_8, vstart=3, vl=8 -> 1 beat, off=0, be=16'h00F8, last=1.
REQ-036 vstart=7, vl=7 -> no beat_valid_o; done_o pulses the cycle after accept.
REQ-037 Hold beat_ready_i low 5 cycles on the first beat -> outputs stable; stall_cnt_o=5 with the macro, 0 without.
REQ-038 Assert rst_ni low mid-RUN -> IDLE, no done_o, ready=1; the next request is processed normally.
